program_loader: RTL
===================

# program_loader

Writer-side counterpart of the instruction memory. It accepts a framed byte stream (length header, payload, checksum) over a valid/ready handshake and emits byte-wide write strobes that fill the instruction memory from a base address. While the load is in progress it holds the processor in stall. Byte order in memory is little-endian, identical to the fetch side, so payload byte i lands at address BASE+i.

## Interface
- ADDR_W, default 6: memory depth is 2^ADDR_W bytes (64).
- BASE, default 0: byte address of the first payload byte.
- CLK  in  1  single clock; all state updates on the rising edge.
- RST  in  1  reset, synchronous and active-high.
- START  in  1  begins a new load when sampled high in IDLE, DONE or ERROR.
- DIN  in  8  stream byte.
- DIN_VALID  in  1  DIN holds a valid byte.
- DIN_READY  out  1  loader can accept a byte this cycle.
- WE  out  1  memory byte-write strobe, one cycle per payload byte.
- WADDR  out  32  byte address for WE.
- WDATA  out  8  byte for WE.
- BUSY  out  1  load frame in progress.
- DONE  out  1  last frame completed with a good checksum.
- ERR  out  1  last frame rejected.
- HOLD  out  1  processor stall; high unless in DONE.

## Operation
- A byte transfers on any rising edge where DIN_VALID and DIN_READY are both high. DIN_VALID gaps are legal.
- Frame format:
  - LEN_LO, then LEN_HI, forming N (16-bit, little-endian, byte count).
  - N payload bytes.
  - One checksum byte equal to the sum of the payload bytes mod 256.
- FSM states: IDLE, LEN0, LEN1, DATA, CSUM, DONE, ERROR.
  - IDLE/DONE/ERROR + START -> LEN0. Byte counter and checksum accumulator clear to 0.
  - LEN0 + transfer -> LEN1 (latch low byte).
  - LEN1 + transfer:
    - N > 2^ADDR_W -> ERROR, with no writes.
    - N == 0 -> CSUM.
    - otherwise -> DATA.
  - DATA + transfer: issue a write of DIN to BASE+count; count++; sum += DIN (8-bit wrap). When count reaches N -> CSUM.
  - CSUM + transfer: DIN == sum -> DONE, else -> ERROR.
- START is ignored in LEN0, LEN1, DATA and CSUM.
- DIN_READY = 1 only in LEN0, LEN1, DATA and CSUM.
- BUSY = DIN_READY. DONE and ERR are levels that follow the state until the next START.
- Bytes already written before a checksum failure are not rolled back. HOLD stays high in ERROR, so the processor never runs a bad image.
- WADDR is 32 bits. The upper bits are BASE's upper bits; address arithmetic does not wrap within 2^ADDR_W.

## Timing
- Reset values:
  - state IDLE
  - DIN_READY=0, WE=0, WADDR=0, WDATA=0
  - BUSY=0, DONE=0, ERR=0, HOLD=1
- Write latency: a payload byte accepted at edge k gives WE=1 with its WADDR/WDATA during cycle k..k+1. The memory captures it at edge k+1. WE is registered and lasts exactly one cycle per byte.
- Throughput: one byte per cycle with DIN_VALID held high. Minimum frame length is N+3 transfer cycles after the START cycle.
- START is sampled at edge s. DIN_READY=1 from cycle s+1.
- Last payload byte: DIN_READY stays high, so the checksum byte may be accepted on the very next edge, while WE for the last payload byte is still in flight.
- DONE and HOLD=0 become visible the cycle after the checksum transfer edge. The WE for the final byte has already completed by then.
- RST high at any edge, including mid-DATA: return to reset values on that edge. Any WE pending for the next cycle is dropped and no further writes occur.
- START and RST at the same edge: RST wins.

## Test plan
- Nominal load: START, then stream 04 00 FF 00 00 00 FF, VALID held high.
  - WE pulses at WADDR 0,1,2,3 with WDATA FF,00,00,00.
  - Then DONE=1, HOLD=0, BUSY=0.
  - Fetch word at 0 reads 0x000000FF.
- Backpressure/gaps: same frame with DIN_VALID toggling 1,0,0,1 per byte.
  - Identical writes.
  - DIN_READY never drops mid-frame.
  - No write occurs in cycles without a transfer.
- Bad checksum: 02 00 12 34 00 (good checksum is 0x46).
  - Two writes (0:12, 1:34).
  - Then ERR=1, DONE=0, HOLD=1.
  - A following START plus a good frame reaches DONE.
- Oversize and empty:
  - 41 00 -> ERROR immediately, zero WE pulses, the next byte is not accepted.
  - 00 00 00 -> DONE with zero writes.
- Reset mid-load: assert RST after the second payload byte is accepted.
  - The next cycle shows the reset values and WE=0.
  - Remaining bytes are not accepted.
- START while busy: pulse START in DATA.
  - Ignored: count continues and the frame completes with DONE.

Source files
------------

// File: rtl/program_loader_if.sv
// Stream-in / memory-write bundle between a byte-stream host and the program loader.
// master = host side (drives the stream, observes writes); slave = loader.
interface program_loader_if;
    logic [7:0]  din;
    logic        din_valid;
    logic        din_ready;
    logic        we;
    logic [31:0] waddr;
    logic [7:0]  wdata;

    modport master (output din, din_valid, input din_ready, we, waddr, wdata);
    modport slave  (input din, din_valid, output din_ready, we, waddr, wdata);
endinterface

// File: rtl/program_loader.sv
// Loads a framed byte stream (LEN_LO, LEN_HI, payload, checksum) into instruction memory
// as byte writes from BASE, stalling the processor until a frame completes with a good checksum.
module program_loader #(
    parameter int unsigned ADDR_W = 6,
    parameter logic [31:0] BASE   = 32'h0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    program_loader_if.slave  bus,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic             hold_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN0, S_LEN1, S_DATA, S_CSUM, S_DONE, S_ERROR
    } state_e;

    localparam logic [16:0] MAX_LEN = 17'(1) << ADDR_W;

    state_e      state_q, state_d;
    logic [7:0]  len_lo_q, len_lo_d;
    logic [15:0] len_q, len_d;
    logic [15:0] count_q, count_d;
    logic [7:0]  sum_q, sum_d;
    logic        we_q, we_d;
    logic [31:0] waddr_q, waddr_d;
    logic [7:0]  wdata_q, wdata_d;

    logic        ready;
    logic        xfer;
    logic [15:0] frame_len;

    assign ready = (state_q == S_LEN0) || (state_q == S_LEN1) ||
                   (state_q == S_DATA) || (state_q == S_CSUM);
    assign xfer      = bus.din_valid && ready;
    assign frame_len = {bus.din, len_lo_q};

    always_comb begin
        // NOTE: every _d gets its hold value first, so no branch can leave one unassigned (no latch).
        state_d  = state_q;
        len_lo_d = len_lo_q;
        len_d    = len_q;
        count_d  = count_q;
        sum_d    = sum_q;
        we_d     = 1'b0;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;

        unique case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start_i) begin
                    state_d = S_LEN0;
                    count_d = '0;
                    sum_d   = '0;
                end
            end
            S_LEN0: begin
                if (xfer) begin
                    len_lo_d = bus.din;
                    state_d  = S_LEN1;
                end
            end
            S_LEN1: begin
                if (xfer) begin
                    len_d = frame_len;
                    if ({1'b0, frame_len} > MAX_LEN) state_d = S_ERROR;
                    else if (frame_len == 16'd0)     state_d = S_CSUM;
                    else                             state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (xfer) begin
                    we_d    = 1'b1;
                    waddr_d = BASE + 32'(count_q);
                    wdata_d = bus.din;
                    count_d = count_q + 16'd1;
                    sum_d   = sum_q + bus.din;
                    if (count_q + 16'd1 == len_q) state_d = S_CSUM;
                end
            end
            S_CSUM: begin
                if (xfer) state_d = (bus.din == sum_q) ? S_DONE : S_ERROR;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Reset drops any write staged for the next cycle, so nothing lands after RST.
    always_ff @(posedge clk_i) begin
        // NOTE: state registers use non-blocking assignments so all of them update from pre-edge values.
        if (rst_i) begin
            state_q  <= S_IDLE;
            len_lo_q <= '0;
            len_q    <= '0;
            count_q  <= '0;
            sum_q    <= '0;
            we_q     <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            len_lo_q <= len_lo_d;
            len_q    <= len_d;
            count_q  <= count_d;
            sum_q    <= sum_d;
            we_q     <= we_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
        end
    end

    assign bus.din_ready = ready;
    assign bus.we        = we_q;
    assign bus.waddr     = waddr_q;
    assign bus.wdata     = wdata_q;
    assign busy_o        = ready;
    assign done_o        = (state_q == S_DONE);
    assign err_o         = (state_q == S_ERROR);
    assign hold_o        = (state_q != S_DONE);

endmodule
